thumb_fetch: RTL and testbench

THUMB_FETCH -- requirements
Module: thumb_fetch

---
 rtl/thumb_fetch.sv | 139 +++++++++++++
 tb/tb_thumb_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/thumb_fetch.sv
// Thumb instruction prefetch: fetches 32-bit words from instruction memory and
// queues them as halfwords, with pc, for the execute stage.
// state | meaning
// IDLE  | no memory request outstanding
// REQ   | request outstanding, returned word is kept
// DROP  | request outstanding, returned word is thrown away (redirected)
module thumb_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        sck,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [15:0] cmd,
    output logic [31:0] cmd_pc,
    output logic        cmd_valid,
    input  logic        cmd_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     fetch_addr;
    logic [31:0]     req_addr;
    logic            skip;
    logic [15:0]     mem_data [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   wr_ptr_p1;
    logic [CW-1:0]   count;
    logic            accept;
    logic            push_one;
    logic            push_two;
    logic            pop;
    logic [1:0]      push_n;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept    = (state == REQ) && imem_ack && !redirect;
    assign push_one  = accept && skip;
    assign push_two  = accept && !skip;
    assign push_n    = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);
    assign cmd_valid = (count != '0) && !redirect;
    assign pop       = cmd_valid && cmd_ready;
    assign wr_ptr_p1 = ptr_inc(wr_ptr);
    assign cmd       = mem_data[rd_ptr];
    assign cmd_pc    = mem_pc[rd_ptr];
    assign imem_addr = req_addr;

    always_ff @(posedge sck) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!redirect && (count <= CW'(DEPTH - 2))) state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == REQ) || (state == DROP);
    end

    // req_addr holds the outstanding address even when a redirect moves fetch_addr.
    always_ff @(posedge sck) begin
        if (rst) begin
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            skip       <= RESET_PC[1];
            req_addr   <= {RESET_PC[31:2], 2'b00};
        end else begin
            if (redirect) begin
                fetch_addr <= {redirect_pc[31:2], 2'b00};
                skip       <= redirect_pc[1];
            end else if (accept) begin
                fetch_addr <= fetch_addr + 32'd4;
                skip       <= 1'b0;
            end
            if ((state == IDLE) && (state_nxt == REQ)) begin
                req_addr <= fetch_addr;
            end
        end
    end

    always_ff @(posedge sck) begin
        if (rst || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_two) begin
                wr_ptr <= ptr_inc(wr_ptr_p1);
            end else if (push_one) begin
                wr_ptr <= wr_ptr_p1;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push_n) - CW'(pop);
        end
    end

    always_ff @(posedge sck) begin
        if (push_two) begin
            mem_data[wr_ptr]    <= imem_rdata[15:0];
            mem_pc[wr_ptr]      <= req_addr;
            mem_data[wr_ptr_p1] <= imem_rdata[31:16];
            mem_pc[wr_ptr_p1]   <= {req_addr[31:2], 2'b10};
        end else if (push_one) begin
            mem_data[wr_ptr]    <= imem_rdata[31:16];
            mem_pc[wr_ptr]      <= {req_addr[31:2], 2'b10};
        end
    end
endmodule

// File: tb/tb_thumb_fetch.sv
// Directed bench for thumb_fetch: reset, streaming, backpressure, redirects,
// drop of stale data, address wrap and reset mid-request.
module tb_thumb_fetch;
    logic        sck = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] cmd;
    logic [31:0] cmd_pc;
    logic        cmd_valid;
    logic        cmd_ready;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;

    always #5 sck = ~sck;

    thumb_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .sck(sck), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .cmd(cmd), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
    );

    // Memory contents: word at a is {BBBB^a[15:0], AAAA^a[15:0]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hBBBB ^ a[15:0], 16'hAAAA ^ a[15:0]};
    endfunction

    function automatic logic [15:0] exp_half(input logic [31:0] p);
        logic [31:0] w;
        w = mem_word({p[31:2], 2'b00});
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            if (cmd_valid && cmd_ready) begin
                chk("stream_pc", cmd_pc, exp_pc);
                chk("stream_cmd", {16'h0, cmd}, {16'h0, exp_half(exp_pc)});
                exp_pc += 32'd2;
            end
            if (imem_req && imem_ack) begin
                chk("stream_addr", imem_addr, exp_addr);
                exp_addr += 32'd4;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; cmd_ready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Basic stream from reset
        rst = 1'b0; imem_ack = 1'b1; cmd_ready = 1'b1;
        tick();
        chk("lat_req", {31'h0, imem_req}, 32'h1);
        chk("lat_addr", imem_addr, 32'h0);
        chk("lat_valid", {31'h0, cmd_valid}, 32'h0);
        tick();
        chk("first_valid", {31'h0, cmd_valid}, 32'h1);
        chk("first_cmd", {16'h0, cmd}, 32'h0000_AAAA);
        chk("first_pc", cmd_pc, 32'h0);
        chk("first_req_gap", {31'h0, imem_req}, 32'h0);
        tick();
        chk("second_cmd", {16'h0, cmd}, 32'h0000_BBBB);
        chk("second_pc", cmd_pc, 32'h2);
        chk("second_addr", imem_addr, 32'h4);
        exp_pc = 32'h2; exp_addr = 32'h4;
        stream(21);

        // Backpressure: FIFO fills to 4 and fetching stops
        cmd_ready = 1'b0;
        stream(6);
        chk("full_count", 32'(dut.count), 32'd4);
        chk("full_req", {31'h0, imem_req}, 32'h0);
        chk("full_valid", {31'h0, cmd_valid}, 32'h1);
        chk("full_head", cmd_pc, exp_pc);
        cmd_ready = 1'b1;
        stream(20);

        // Redirect to high half with an empty FIFO
        do_reset();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0102; imem_ack = 1'b1; cmd_ready = 1'b1;
        tick();
        redirect = 1'b0;
        chk("rd_idle", {31'h0, imem_req}, 32'h0);
        tick();
        chk("rd_req", {31'h0, imem_req}, 32'h1);
        chk("rd_addr", imem_addr, 32'h0000_0100);
        tick();
        chk("rd_valid", {31'h0, cmd_valid}, 32'h1);
        chk("rd_pc", cmd_pc, 32'h0000_0102);
        chk("rd_cmd", {16'h0, cmd}, 32'h0000_BABB);
        exp_pc = 32'h102; exp_addr = 32'h104;
        stream(6);

        // Redirect during a slow request, then again while dropping
        do_reset();
        rst = 1'b0; cmd_ready = 1'b1;
        tick();
        chk("drop_req0", imem_addr, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        tick();
        redirect = 1'b0;
        chk("drop_req1", {31'h0, imem_req}, 32'h1);
        chk("drop_addr1", imem_addr, 32'h0);
        chk("drop_valid1", {31'h0, cmd_valid}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h0000_0302;
        tick();
        redirect = 1'b0;
        chk("drop_addr2", imem_addr, 32'h0);
        tick();
        imem_ack = 1'b1;
        tick();
        chk("drop_done_req", {31'h0, imem_req}, 32'h0);
        chk("drop_done_valid", {31'h0, cmd_valid}, 32'h0);
        tick();
        chk("drop_new_addr", imem_addr, 32'h0000_0300);
        tick();
        chk("drop_new_valid", {31'h0, cmd_valid}, 32'h1);
        chk("drop_new_pc", cmd_pc, 32'h0000_0302);
        chk("drop_new_cmd", {16'h0, cmd}, 32'h0000_B8BB);

        // Redirect on the ack edge discards the word
        do_reset();
        rst = 1'b0;
        tick();
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        chk("ackrd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("ackrd_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("ackrd_addr", imem_addr, 32'h0000_0040);
        tick();
        chk("ackrd_pc", cmd_pc, 32'h0000_0040);
        chk("ackrd_cmd", {16'h0, cmd}, 32'h0000_AAEA);

        // Fetch address wrap
        do_reset();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc0", cmd_pc, 32'hFFFF_FFFC);
        chk("wrap_cmd0", {16'h0, cmd}, 32'h0000_5556);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        cmd_ready = 1'b1;
        tick();
        chk("wrap_pc1", cmd_pc, 32'hFFFF_FFFE);
        chk("wrap_cmd1", {16'h0, cmd}, 32'h0000_4447);
        tick();
        chk("wrap_pc2", cmd_pc, 32'h0);
        chk("wrap_cmd2", {16'h0, cmd}, 32'h0000_AAAA);
        redirect = 1'b1; redirect_pc = 32'h0;
        #1;
        chk("redir_masks_valid", {31'h0, cmd_valid}, 32'h0);

        // Reset pulsed mid-request with a non-empty FIFO
        do_reset();
        rst = 1'b0; imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        tick();
        chk("rstmid_req", {31'h0, imem_req}, 32'h1);
        chk("rstmid_addr", imem_addr, 32'h4);
        chk("rstmid_count", 32'(dut.count), 32'd2);
        rst = 1'b1; imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0500;
        tick();
        chk("rstmid_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rstmid_req0", {31'h0, imem_req}, 32'h0);
        chk("rstmid_count0", 32'(dut.count), 32'd0);
        rst = 1'b0; redirect = 1'b0;
        tick();
        chk("rstmid_restart", imem_addr, 32'h0);
        chk("rstmid_restart_req", {31'h0, imem_req}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
